// File: rtl/hpm_counters_if.sv
// ============================================================================
// Module      : hpm_counters_if
// Description : CSR read/write port bundle for the performance counter block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hpm_counters_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int CSR_ADDR_WIDTH = 12
) ();

  logic                      we_i;
  logic [CSR_ADDR_WIDTH-1:0] waddr_i;
  logic [DATA_WIDTH-1:0]     wdata_i;
  logic [CSR_ADDR_WIDTH-1:0] raddr_i;
  logic [DATA_WIDTH-1:0]     rdata_o;
  logic                      rillegal_o;

  modport master (
    output we_i, waddr_i, wdata_i, raddr_i,
    input  rdata_o, rillegal_o
  );

  modport slave (
    input  we_i, waddr_i, wdata_i, raddr_i,
    output rdata_o, rillegal_o
  );

endinterface

`default_nettype wire

// File: rtl/hpm_counters.sv
// ============================================================================
// Module      : hpm_counters
// Description : mcycle, minstret and NUM_EVENTS 64-bit event counters with CSR
//               access; mcountinhibit gating enabled by macro HPM_INHIBIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hpm_counters #(
  parameter int DATA_WIDTH     = 32,
  parameter int CSR_ADDR_WIDTH = 12,
  parameter int NUM_EVENTS     = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  hpm_counters_if.slave         csr,
  input  logic                  retire_i,
  input  logic [NUM_EVENTS-1:0] event_i
);

  // Counter slots: 0 = mcycle, 1 = minstret, 2+k = event counter k.
  localparam int          c_num_cnt  = NUM_EVENTS + 2;
  localparam int          c_idx_w    = $clog2(c_num_cnt);
  localparam int          c_inh_w    = NUM_EVENTS + 3;
  localparam logic [31:0] c_addr_lo  = 32'hB00;
  localparam logic [31:0] c_addr_hi  = 32'hB80;
  localparam logic [31:0] c_addr_inh = 32'h320;

  typedef struct packed {
    logic               hit;
    logic               hi;
    logic               inh;
    logic [c_idx_w-1:0] idx;
  } dec_t;

  function automatic dec_t decode(input logic [CSR_ADDR_WIDTH-1:0] addr);
    logic [31:0] a;
    logic [31:0] off;
    logic        in_lo;
    logic        in_hi;
    decode = '0;
    a      = 32'(addr);
    in_lo  = (a >= c_addr_lo) && (a < c_addr_lo + 32'(c_inh_w));
    in_hi  = (DATA_WIDTH == 32) && (a >= c_addr_hi) && (a < c_addr_hi + 32'(c_inh_w));
    off    = in_hi ? (a - c_addr_hi) : (a - c_addr_lo);
    if (a == c_addr_inh) begin
`ifdef HPM_INHIBIT_EN
      decode.hit = 1'b1;
      decode.inh = 1'b1;
`endif
    end else if ((in_lo || in_hi) && (off != 32'd1)) begin
      // Offset 1 is the unimplemented time CSR; slots above it shift down by one.
      decode.hit = 1'b1;
      decode.hi  = in_hi;
      decode.idx = (off == 32'd0) ? '0 : c_idx_w'(off - 32'd1);
    end
  endfunction

  dec_t                  w_wdec;
  dec_t                  w_rdec;
  logic [c_inh_w-1:0]    w_inh;
  logic [c_num_cnt-1:0]  w_inc;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [63:0]           cnt_q [c_num_cnt];
  logic [63:0]           cnt_d [c_num_cnt];

  assign w_wdec = decode(csr.waddr_i);
  assign w_rdec = decode(csr.raddr_i);

`ifdef HPM_INHIBIT_EN
  localparam logic [c_inh_w-1:0] c_inh_mask = ~c_inh_w'(2);

  logic [c_inh_w-1:0] inh_q;
  logic [c_inh_w-1:0] inh_d;

  always_comb begin
    inh_d = inh_q;
    if (csr.we_i && w_wdec.hit && w_wdec.inh) begin
      inh_d = csr.wdata_i[c_inh_w-1:0] & c_inh_mask;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inh_q <= '0;
    end else begin
      inh_q <= inh_d;
    end
  end

  assign w_inh = inh_q;
`else
  assign w_inh = '0;
`endif

  always_comb begin
    w_inc[0] = ~w_inh[0];
    w_inc[1] = retire_i & ~w_inh[2];
    for (int k = 0; k < NUM_EVENTS; k++) begin
      w_inc[k+2] = event_i[k] & ~w_inh[k+3];
    end
  end

  // A write replaces the increment outright; the untouched half keeps its old value.
  always_comb begin
    for (int i = 0; i < c_num_cnt; i++) begin
      cnt_d[i] = cnt_q[i] + {63'd0, w_inc[i]};
      if (csr.we_i && w_wdec.hit && !w_wdec.inh && (w_wdec.idx == c_idx_w'(i))) begin
        if (DATA_WIDTH == 64) begin
          cnt_d[i] = 64'(csr.wdata_i);
        end else if (w_wdec.hi) begin
          cnt_d[i] = {csr.wdata_i[31:0], cnt_q[i][31:0]};
        end else begin
          cnt_d[i] = {cnt_q[i][63:32], csr.wdata_i[31:0]};
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < c_num_cnt; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < c_num_cnt; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_rdec.hit) begin
      if (w_rdec.inh) begin
        w_rdata = DATA_WIDTH'(w_inh);
      end else if (DATA_WIDTH == 64) begin
        w_rdata = DATA_WIDTH'(cnt_q[w_rdec.idx]);
      end else if (w_rdec.hi) begin
        w_rdata = DATA_WIDTH'(cnt_q[w_rdec.idx][63:32]);
      end else begin
        w_rdata = DATA_WIDTH'(cnt_q[w_rdec.idx][31:0]);
      end
    end
  end

  assign csr.rdata_o    = w_rdata;
  assign csr.rillegal_o = ~w_rdec.hit;

endmodule

`default_nettype wire

// File: tb/tb_hpm_counters.sv
// ============================================================================
// Module      : tb_hpm_counters
// Description : Randomised bench for hpm_counters against a CSR-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hpm_counters;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int NE = 2;
`ifdef HPM_INHIBIT_EN
  localparam bit INH_EN = 1'b1;
`else
  localparam bit INH_EN = 1'b0;
`endif
  localparam logic [31:0] INH_MASK = ((32'd1 << (NE + 3)) - 32'd1) & ~32'd2;

  logic          clk    = 1'b0;
  logic          rst    = 1'b1;
  logic          retire = 1'b0;
  logic [NE-1:0] ev     = '0;

  hpm_counters_if #(.DATA_WIDTH(DW), .CSR_ADDR_WIDTH(AW)) csr_if ();

  hpm_counters #(
    .DATA_WIDTH     (DW),
    .CSR_ADDR_WIDTH (AW),
    .NUM_EVENTS     (NE)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .csr      (csr_if),
    .retire_i (retire),
    .event_i  (ev)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model indexed by CSR offset from 0xB00 (offset 1 is the absent time CSR).
  logic [63:0] m_cnt [NE+3];
  logic [31:0] m_inh;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int o = 0; o < NE + 3; o++) m_cnt[o] = '0;
    m_inh = '0;
  endtask

  function automatic bit is_lo(input int a);
    return (a >= 'hB00) && (a <= 'hB02 + NE) && (a != 'hB01);
  endfunction

  function automatic bit is_hi(input int a);
    return (DW == 32) && (a >= 'hB80) && (a <= 'hB82 + NE) && (a != 'hB81);
  endfunction

  task automatic m_read(input logic [11:0] addr, output logic [31:0] d, output logic ill);
    int a;
    a   = int'(addr);
    d   = '0;
    ill = 1'b1;
    if (a == 'h320) begin
      if (INH_EN) begin
        d   = m_inh;
        ill = 1'b0;
      end
    end else if (is_lo(a)) begin
      d   = m_cnt[a - 'hB00][31:0];
      ill = 1'b0;
    end else if (is_hi(a)) begin
      d   = m_cnt[a - 'hB80][63:32];
      ill = 1'b0;
    end
  endtask

  task automatic m_step(input bit we, input logic [11:0] wa, input logic [31:0] wd,
                        input bit ret, input logic [NE-1:0] e);
    logic [63:0] nxt [NE+3];
    int          a;
    bit          inc;
    a = int'(wa);
    for (int o = 0; o < NE + 3; o++) begin
      if (o == 0)      inc = !m_inh[0];
      else if (o == 2) inc = ret && !m_inh[2];
      else if (o >= 3) inc = e[o-3] && !m_inh[o];
      else             inc = 1'b0;
      nxt[o] = m_cnt[o] + 64'(inc);
    end
    if (we) begin
      if (is_lo(a))                  nxt[a - 'hB00] = {m_cnt[a - 'hB00][63:32], wd};
      else if (is_hi(a))             nxt[a - 'hB80] = {wd, m_cnt[a - 'hB80][31:0]};
      else if (a == 'h320 && INH_EN) m_inh = wd & INH_MASK;
    end
    for (int o = 0; o < NE + 3; o++) m_cnt[o] = nxt[o];
  endtask

  task automatic cyc(input bit we, input logic [11:0] wa, input logic [31:0] wd,
                     input logic [11:0] ra, input bit ret, input logic [NE-1:0] e);
    logic [31:0] ed;
    logic        ei;
    csr_if.we_i    = we;
    csr_if.waddr_i = wa;
    csr_if.wdata_i = wd;
    csr_if.raddr_i = ra;
    retire         = ret;
    ev             = e;
    #1;
    m_read(ra, ed, ei);
    chk("cyc_rdata", 64'(csr_if.rdata_o), 64'(ed));
    chk("cyc_rill", {63'd0, csr_if.rillegal_o}, {63'd0, ei});
    @(posedge clk);
    m_step(we, wa, wd, ret, e);
    #1;
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] ed, input logic ei);
    csr_if.raddr_i = a;
    #1;
    chk({tag, "_data"}, 64'(csr_if.rdata_o), 64'(ed));
    chk({tag, "_ill"}, {63'd0, csr_if.rillegal_o}, {63'd0, ei});
  endtask

  function automatic logic [11:0] pick();
    case ($urandom_range(0, 5))
      0:       return 12'hB00 + 12'($urandom_range(0, NE + 3));
      1:       return 12'hB80 + 12'($urandom_range(0, NE + 3));
      2:       return 12'h320;
      3:       return 12'($urandom);
      default: return 12'hB00 + 12'($urandom_range(0, NE + 2));
    endcase
  endfunction

  function automatic logic [31:0] rnd_data();
    if ($urandom_range(0, 2) == 0) return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
    return 32'($urandom);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1);
  end

  initial begin
    csr_if.we_i    = 1'b0;
    csr_if.waddr_i = '0;
    csr_if.wdata_i = '0;
    csr_if.raddr_i = 12'hB00;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rd("rst_mcycle", 12'hB00, 32'd0, 1'b0);
    rd("rst_time", 12'hB01, 32'd0, 1'b1);
    rd("rst_inh", 12'h320, 32'd0, !INH_EN);
    rst = 1'b0;

    repeat (10) cyc(1'b0, 12'h0, 32'h0, 12'hB00, 1'b0, '0);
    rd("mcycle10", 12'hB00, 32'd10, 1'b0);
    rd("ev0_zero", 12'hB03, 32'd0, 1'b0);
    rd("time_ill", 12'hB01, 32'd0, 1'b1);

    cyc(1'b1, 12'hB00, 32'hFFFF_FFFE, 12'hB00, 1'b0, '0);
    cyc(1'b0, 12'h0, 32'h0, 12'hB00, 1'b0, '0);
    cyc(1'b1, 12'hB80, 32'h0000_0007, 12'hB80, 1'b0, '0);
    repeat (2) cyc(1'b0, 12'h0, 32'h0, 12'hB00, 1'b0, '0);
    rd("carry_lo", 12'hB00, 32'h0000_0001, 1'b0);
    rd("carry_hi", 12'hB80, 32'h0000_0008, 1'b0);

    for (int c = 0; c < 5; c++) cyc(c == 2, 12'hB04, 32'd100, 12'hB04, 1'b0, 2'b10);
    rd("write_wins", 12'hB04, 32'd102, 1'b0);

`ifdef HPM_INHIBIT_EN
    cyc(1'b1, 12'h320, 32'h5, 12'h320, 1'b0, '0);
    repeat (20) cyc(1'b0, 12'h0, 32'h0, 12'hB02, 1'b1, 2'b11);
    rd("cy_frozen", 12'hB00, m_cnt[0][31:0], 1'b0);
    rd("ir_frozen", 12'hB02, 32'd0, 1'b0);
    rd("ev_counts", 12'hB03, 32'd20, 1'b0);
    rd("inh_read", 12'h320, 32'h5, 1'b0);
    cyc(1'b1, 12'h320, 32'h0, 12'h320, 1'b0, '0);
    repeat (5) cyc(1'b0, 12'h0, 32'h0, 12'hB02, 1'b1, '0);
    rd("ir_resume", 12'hB02, 32'd5, 1'b0);
`else
    cyc(1'b1, 12'h320, 32'h5, 12'h320, 1'b0, '0);
    rd("inh_absent", 12'h320, 32'd0, 1'b1);
`endif

    cyc(1'b1, 12'hB03, 32'hFFFF_FFFF, 12'hB03, 1'b0, '0);
    cyc(1'b1, 12'hB83, 32'hFFFF_FFFF, 12'hB83, 1'b0, '0);
    rd("all_ones_lo", 12'hB03, 32'hFFFF_FFFF, 1'b0);
    cyc(1'b0, 12'h0, 32'h0, 12'hB83, 1'b0, 2'b01);
    rd("wrap_lo", 12'hB03, 32'd0, 1'b0);
    rd("wrap_hi", 12'hB83, 32'd0, 1'b0);

    repeat (400) cyc($urandom_range(0, 3) == 0, pick(), rnd_data(), pick(),
                     1'($urandom_range(0, 1)), NE'($urandom));

    repeat (3) cyc(1'b0, 12'h0, 32'h0, 12'hB00, 1'b1, 2'b11);
    #2;
    rst = 1'b1;
    m_reset();
    rd("arst_mcycle", 12'hB00, 32'd0, 1'b0);
    rd("arst_ev0", 12'hB03, 32'd0, 1'b0);
    rd("arst_ev0_hi", 12'hB83, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) cyc(1'b0, 12'h0, 32'h0, 12'hB00, 1'b0, '0);
    rd("post_rst", 12'hB00, 32'd3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
